// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control propagation, hazard stall and flush.
// Define CTRL_FWD_EN to build operand forwarding (only load-use then stalls).
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int EX_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [EX_W-1:0]  ex_d,
  input  logic [1:0]       mem_d,
  input  logic [1:0]       wb_d,
  input  logic             jal_in,
  input  logic             syscall_in,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic             stall,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [1:0]       mem_ctrl,
  output logic [1:0]       mem_wb_ctrl,
  output logic [REG_W-1:0] mem_dest,
  output logic [1:0]       wb_ctrl,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_syscall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [1:0]       mem;
    logic [1:0]       wb;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             sys;
  } id_ex_t;

  typedef struct packed {
    logic [1:0]       mem;
    logic [1:0]       wb;
    logic [REG_W-1:0] dest;
    logic             sys;
  } ex_mem_t;

  typedef struct packed {
    logic [1:0]       wb;
    logic [REG_W-1:0] dest;
    logic             sys;
  } mem_wb_t;

  id_ex_t  idex;
  ex_mem_t exmem;
  mem_wb_t memwb;

  logic [REG_W-1:0] id_dest;
  logic             hazard;
  logic             bubble;
  logic             idex_w;
  logic             exmem_w;

  always_comb begin
    if (jal_in)
      id_dest = REG_W'(31);
    else if (ex_d[EX_W-1])
      id_dest = id_rd;
    else
      id_dest = id_rt;
  end

  // Writes to register 0 are discarded, so they never create a dependency
  assign idex_w  = idex.wb[1] && (idex.dest != '0);
  assign exmem_w = exmem.wb[1] && (exmem.dest != '0);

`ifdef CTRL_FWD_EN
  logic memwb_w;
  logic load_use;

  assign memwb_w  = memwb.wb[1] && (memwb.dest != '0);
  assign load_use = idex.mem[0] && (idex.dest != '0) &&
                    ((idex.dest == id_rs) || (idex.dest == id_rt));
  assign hazard   = load_use;

  assign fwd_a = (exmem_w && exmem.dest == idex.rs) ? 2'b10 :
                 (memwb_w && memwb.dest == idex.rs) ? 2'b01 : 2'b00;
  assign fwd_b = (exmem_w && exmem.dest == idex.rt) ? 2'b10 :
                 (memwb_w && memwb.dest == idex.rt) ? 2'b01 : 2'b00;
`else
  logic rs_dep;
  logic rt_dep;

  // No bypass: wait until the producer has left EX/MEM
  assign rs_dep = (id_rs != '0) &&
                  ((idex_w && idex.dest == id_rs) ||
                   (exmem_w && exmem.dest == id_rs));
  assign rt_dep = (id_rt != '0) &&
                  ((idex_w && idex.dest == id_rt) ||
                   (exmem_w && exmem.dest == id_rt));
  assign hazard = rs_dep || rt_dep;

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  assign stall  = hazard && !flush;
  assign bubble = hazard || flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      if (bubble)
        idex <= '0;
      else
        idex <= '{ex: ex_d, mem: mem_d, wb: wb_d, dest: id_dest,
                  rs: id_rs, rt: id_rt, sys: syscall_in};
      exmem <= '{mem: idex.mem, wb: idex.wb,
                 dest: idex.dest, sys: idex.sys};
      memwb <= '{wb: exmem.wb, dest: exmem.dest, sys: exmem.sys};
    end
  end

  assign ex_ctrl     = idex.ex;
  assign ex_rs       = idex.rs;
  assign ex_rt       = idex.rt;
  assign mem_ctrl    = exmem.mem;
  assign mem_wb_ctrl = exmem.wb;
  assign mem_dest    = exmem.dest;
  assign wb_ctrl     = memwb.wb;
  assign wb_dest     = memwb.dest;
  assign wb_syscall  = memwb.sys;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed checks of ctrl_pipe stage registers, hazards, forwarding.
// Expectations follow the CTRL_FWD_EN setting of the build.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] ex_d;
  logic [1:0] mem_d;
  logic [1:0] wb_d;
  logic       jal_in;
  logic       syscall_in;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic       stall;
  logic [6:0] ex_ctrl;
  logic [4:0] ex_rs, ex_rt;
  logic [1:0] mem_ctrl, mem_wb_ctrl;
  logic [4:0] mem_dest;
  logic [1:0] wb_ctrl;
  logic [4:0] wb_dest;
  logic       wb_syscall;
  logic [1:0] fwd_a, fwd_b;

  int errors = 0;
  int checks = 0;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .ex_d(ex_d), .mem_d(mem_d), .wb_d(wb_d),
    .jal_in(jal_in), .syscall_in(syscall_in),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_ctrl(mem_ctrl), .mem_wb_ctrl(mem_wb_ctrl), .mem_dest(mem_dest),
    .wb_ctrl(wb_ctrl), .wb_dest(wb_dest), .wb_syscall(wb_syscall),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] e, input logic [1:0] m,
                       input logic [1:0] w, input logic j, input logic s,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    ex_d = e; mem_d = m; wb_d = w; jal_in = j; syscall_in = s;
    id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
  endtask

  task automatic nop();
    drive(7'h00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    nop();
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    // reset with a fully-set bundle in ID
    drive(7'h7F, 2'b11, 2'b11, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3);
    tick(); tick();
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_mem_ctrl", mem_ctrl, 0);
    chk("rst_mem_wb", mem_wb_ctrl, 0);
    chk("rst_wb_ctrl", wb_ctrl, 0);
    chk("rst_dests", {mem_dest, wb_dest, ex_rs, ex_rt}, 0);
    chk("rst_sys", wb_syscall, 0);
    chk("rst_fwd", {fwd_a, fwd_b}, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_ex_ctrl", ex_ctrl, 7'h7F);
    chk("rel_ex_rsrt", {ex_rs, ex_rt}, {5'd1, 5'd2});
    chk("rel_mem_ctrl", mem_ctrl, 0);
    nop();
    tick();
    chk("rel_mem", {mem_ctrl, mem_wb_ctrl, mem_dest}, {2'b11, 2'b11, 5'd3});
    tick();
    chk("rel_wb", {wb_ctrl, wb_dest}, {2'b11, 5'd3});
    chk("rel_wb_sys", wb_syscall, 1);
    tick();
    chk("rel_wb_sys_off", wb_syscall, 0);
    drain();

    // LW $8 ; ADD $9,$8,$10
    drive(7'h20, 2'b01, 2'b11, 1'b0, 1'b0, 5'd29, 5'd8, 5'd0);
    chk("lw_no_stall", stall, 0);
    tick();
    drive(7'h42, 2'b00, 2'b10, 1'b0, 1'b0, 5'd8, 5'd10, 5'd9);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", ex_ctrl, 0);
    chk("lu_mem_dest", mem_dest, 8);
`ifdef CTRL_FWD_EN
    chk("lu_stall_end", stall, 0);
    tick();
    chk("lu_add_ex", ex_ctrl, 7'h42);
    chk("lu_fwd_a", fwd_a, 2'b01);
    chk("lu_fwd_b", fwd_b, 2'b00);
`else
    chk("lu_stall2", stall, 1);
    tick();
    chk("lu_bubble2", ex_ctrl, 0);
    chk("lu_stall_end", stall, 0);
    tick();
    chk("lu_add_ex", ex_ctrl, 7'h42);
    chk("lu_fwd_a", fwd_a, 2'b00);
`endif
    drain();

    // ADD $3,$1,$2 ; SUB $4,$3,$3
    drive(7'h42, 2'b00, 2'b10, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    drive(7'h43, 2'b00, 2'b10, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4);
`ifdef CTRL_FWD_EN
    chk("raw_no_stall", stall, 0);
    tick();
    chk("raw_sub_ex", ex_ctrl, 7'h43);
    chk("raw_fwd_a", fwd_a, 2'b10);
    chk("raw_fwd_b", fwd_b, 2'b10);
`else
    chk("raw_stall1", stall, 1);
    tick();
    chk("raw_bubble1", ex_ctrl, 0);
    chk("raw_stall2", stall, 1);
    tick();
    chk("raw_bubble2", ex_ctrl, 0);
    chk("raw_stall_end", stall, 0);
    tick();
    chk("raw_sub_ex", ex_ctrl, 7'h43);
    chk("raw_fwd", {fwd_a, fwd_b}, 0);
`endif
    drain();

    // JAL then a reader of $31
    drive(7'h00, 2'b00, 2'b10, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(7'h42, 2'b00, 2'b10, 1'b0, 1'b0, 5'd31, 5'd0, 5'd5);
`ifdef CTRL_FWD_EN
    chk("jal_stall", stall, 0);
`else
    chk("jal_stall", stall, 1);
`endif
    tick();
    chk("jal_mem_dest", mem_dest, 31);
    chk("jal_mem_wb", mem_wb_ctrl, 2'b10);
`ifdef CTRL_FWD_EN
    chk("jal_fwd_a", fwd_a, 2'b10);
`else
    chk("jal_fwd_a", fwd_a, 2'b00);
`endif
    drain();

    // JR with rd=0 and RegWrite=1 writes nothing
    drive(7'h40, 2'b00, 2'b10, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0);
    tick();
    drive(7'h42, 2'b00, 2'b10, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6);
    chk("jr_stall", stall, 0);
    tick();
    chk("jr_mem_dest", mem_dest, 0);
    chk("jr_fwd", {fwd_a, fwd_b}, 0);
    drain();

    // load-use coinciding with flush
    drive(7'h20, 2'b01, 2'b11, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
    tick();
    drive(7'h42, 2'b00, 2'b10, 1'b0, 1'b0, 5'd7, 5'd0, 5'd2);
    chk("fl_pre_stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("fl_bubble", {ex_ctrl, ex_rs}, 0);
    chk("fl_mem_ctrl", mem_ctrl, 2'b01);
    drain();

    // SYSCALL timing
    drive(7'h00, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    nop();
    chk("sys_n1", wb_syscall, 0);
    tick();
    chk("sys_n2", wb_syscall, 0);
    tick();
    chk("sys_n3", wb_syscall, 1);
    tick();
    chk("sys_n4", wb_syscall, 0);
    drain();

    // reset while stalled
    drive(7'h20, 2'b01, 2'b11, 1'b0, 1'b0, 5'd0, 5'd9, 5'd0);
    tick();
    drive(7'h42, 2'b00, 2'b10, 1'b0, 1'b0, 5'd9, 5'd0, 5'd2);
    chk("rs_pre_stall", stall, 1);
    rst_n = 1'b0;
    tick();
    chk("rs_cleared", {ex_ctrl, mem_ctrl, mem_dest}, 0);
    chk("rs_stall", stall, 0);
    rst_n = 1'b1;
    tick();
    chk("rs_capture", ex_ctrl, 7'h42);
    chk("rs_capture_rs", ex_rs, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipeline control-propagation and hazard unit: the consuming end of the instruction decoder's control bundles. Each cycle it captures the decoder's EX/MEM/WB control fields and destination-register selection for the instruction in ID, then carries them through the ID/EX, EX/MEM and MEM/WB stage registers to the datapath. It detects load-use and read-after-write hazards, stalls the front end, inserts bubbles, applies branch/jump flushes and, when configured, generates operand-forwarding selects.

## Interface
- `REG_W`, 5: register-number width.
- `EX_W`, 7: EX bundle width, {RegDst, ALUsrc, ALUop[4:0]}.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ex_d` in EX_W: decoder EX bundle.
- `mem_d` in 2: {MemWrite, MemRead}.
- `wb_d` in 2: {RegWrite, MemToReg}.
- `jal_in` in 1: decoded JAL; forces dest 31.
- `syscall_in` in 1: decoded SYSCALL.
- `id_rs`, `id_rt`, `id_rd` in REG_W: register fields of the instruction in ID.
- `flush` in 1: taken branch/jump resolved; discard the instruction in ID.
- `stall` out 1: hold PC and IF/ID register (combinational).
- `ex_ctrl` out EX_W; `ex_rs`, `ex_rt` out REG_W: ID/EX stage.
- `mem_ctrl` out 2; `mem_wb_ctrl` out 2; `mem_dest` out REG_W: EX/MEM stage.
- `wb_ctrl` out 2; `wb_dest` out REG_W; `wb_syscall` out 1: MEM/WB stage.
- `fwd_a`, `fwd_b` out 2: ALU operand A (rs) / B (rt) source select.

## Operation
- Destination computed in ID: jal_in -> 31; else RegDst (ex_d[6]) -> id_rd; else id_rt. A destination of 0 never counts as a write for hazard or forwarding purposes.
- Stage registers per stage: control bundle, dest, RegWrite, MemRead, syscall flag, and rs/rt (ID/EX only).
- Normal advance: ID -> ID/EX -> EX/MEM -> MEM/WB every cycle.
- Bubble: all control, dest, and syscall fields are zero. ID/EX captures a bubble when `stall` or `flush` is asserted. EX/MEM and MEM/WB always advance.
- Load-use stall: ID/EX MemRead=1, ID/EX dest≠0, and dest equals id_rs or id_rt.
- `flush` has priority over the stall condition. When `flush`=1, `stall` is forced to 0 and ID/EX receives a bubble.
- Forwarding priority for `fwd_a`:
  - 2'b10 if EX/MEM RegWrite, dest≠0, and dest==ex_rs.
  - Else 2'b01 if MEM/WB RegWrite, dest≠0, and dest==ex_rs.
  - Else 2'b00.
- `fwd_b` uses the same rule with ex_rt.
- `wb_syscall` is high for exactly the one cycle a syscall instruction occupies MEM/WB.
- The register file is write-before-read, so MEM/WB-to-ID needs no hazard handling.

## Timing
- Reset: on a rising edge with rst_n=0, every stage register clears to bubble. Resulting output values:
  - ex_ctrl, mem_ctrl, mem_wb_ctrl, wb_ctrl = 0.
  - All dest/rs/rt = 0.
  - wb_syscall = 0, fwd_a = fwd_b = 0, stall = 0.
- Reset mid-stall discards all in-flight state. The first edge after release captures ID normally.
- Latency: a decoded bundle appears on ex_ctrl 1 cycle after capture, on mem_* after 2, and on wb_* after 3.
- stall, fwd_a and fwd_b are combinational from the current stage registers and ID inputs, and are valid in the same cycle.
- A load-use stall lasts exactly 1 cycle with forwarding. After that the load is in EX/MEM, its MemRead no longer matches, and the consumer proceeds with fwd=2'b01 one cycle later.
- Simultaneous stall condition and flush: no stall, bubble inserted.

## Configuration
- `CTRL_FWD_EN` defined: forwarding logic present as above, and only the load-use stall is generated.
- Not defined:
  - fwd_a and fwd_b are tied to 2'b00.
  - `stall` asserts whenever id_rs or id_rt (≠0) equals the dest of a RegWrite=1 instruction in ID/EX or EX/MEM.
  - A dependent instruction therefore waits up to 2 cycles.
  - Flush priority is unchanged.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with ex_d=7'h7F, wb_d=2'b11 -> all outputs 0. Release -> ex_ctrl=7'h7F one cycle later.
- LW $8 followed by ADD $9,$8,$10 -> stall=1 for 1 cycle, ex_ctrl=0 bubble, then fwd_a=2'b01 when the ADD is in EX (with CTRL_FWD_EN).
- ADD $3,$1,$2 followed by SUB $4,$3,$3 with CTRL_FWD_EN -> no stall, fwd_a=fwd_b=2'b10. Without the macro -> stall=1 for 2 cycles.
- JAL followed by a use of $31 -> mem_dest=31. JR with rd=0 -> no forwarding match even though RegWrite=1.
- Load-use condition with flush=1 in the same cycle -> stall=0 and ID/EX bubble.
- SYSCALL decoded at cycle n -> wb_syscall=1 only at cycle n+3.
